// File: rtl/binary_frame_writer.sv
// binary_frame_writer
//   Takes a raster-ordered 8-bit grayscale pixel stream, turns each pixel
//   into one bit by comparing it with binThreshold, and writes that bit at
//   (x, y) into the binary frame memory. After the last pixel of a frame it
//   pulses start to the median filter. It then refuses new pixels until
//   fullImageDone comes back.
//
// Ports
//   clk, reset          : single clock; reset is synchronous and active-high
//   pixelIn[7:0]        : grayscale pixel
//   pixelValid          : pixelIn / pixelSof are valid this cycle
//   pixelSof            : first pixel of a frame
//   pixelReady          : block takes the beat this cycle
//   binThreshold[7:0]   : a pixel strictly above this value gives bit 1
//   fullImageDone       : median filter has finished the current frame
//   xAddressOut, yAddressOut : write address (held between writes)
//   binaryDataOut       : binarized pixel (held between writes)
//   writeBinaryMem      : one-cycle memory write strobe
//   start               : one-cycle pulse to the median filter
//   busy                : high from SOF acceptance until fullImageDone
//   frameError          : sticky; an SOF arrived in the middle of a frame
//
// Handshake: a beat transfers on a cycle where pixelValid && pixelReady are
// both high. pixelReady depends only on the FSM state, never on pixelValid.
// A producer holding pixelValid while pixelReady is low keeps its beat.
module binary_frame_writer #(
  parameter int IMG_WIDTH  = 160,
  parameter int IMG_HEIGHT = 120,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        pixelIn,
  input  logic              pixelValid,
  input  logic              pixelSof,
  output logic              pixelReady,
  input  logic [7:0]        binThreshold,
  input  logic              fullImageDone,
  output logic [ADDR_W-1:0] xAddressOut,
  output logic [ADDR_W-1:0] yAddressOut,
  output logic              binaryDataOut,
  output logic              writeBinaryMem,
  output logic              start,
  output logic              busy,
  output logic              frameError
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITE     = 2'd1;
  localparam logic [1:0] START     = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(IMG_WIDTH - 1);
  localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(IMG_HEIGHT - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] x_cnt;
  logic [ADDR_W-1:0] y_cnt;

  logic              accept;
  logic              do_write;
  logic [ADDR_W-1:0] beat_x;
  logic [ADDR_W-1:0] beat_y;
  logic [ADDR_W-1:0] next_x;
  logic [ADDR_W-1:0] next_y;
  logic              beat_last;
  logic              beat_bit;

  assign pixelReady = (state == IDLE) || (state == WRITE);
  assign accept     = pixelValid && pixelReady;
  // In IDLE only an SOF beat opens a frame. Other beats are consumed and
  // dropped, so the upstream stream can resynchronise on the next SOF.
  assign do_write   = accept && (pixelSof || (state == WRITE));

  always_comb begin
    // An SOF beat always lands at (0,0). Mid-frame this restarts the raster.
    beat_x    = pixelSof ? '0 : x_cnt;
    beat_y    = pixelSof ? '0 : y_cnt;
    beat_last = (beat_x == X_LAST) && (beat_y == Y_LAST);
    beat_bit  = pixelIn > binThreshold;
    if (beat_x == X_LAST) begin
      next_x = '0;
      next_y = beat_y + 1'b1;
    end else begin
      next_x = beat_x + 1'b1;
      next_y = beat_y;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      x_cnt          <= '0;
      y_cnt          <= '0;
      xAddressOut    <= '0;
      yAddressOut    <= '0;
      binaryDataOut  <= 1'b0;
      writeBinaryMem <= 1'b0;
      start          <= 1'b0;
      busy           <= 1'b0;
      frameError     <= 1'b0;
    end else begin
      writeBinaryMem <= 1'b0;
      start          <= 1'b0;

      if (do_write) begin
        xAddressOut    <= beat_x;
        yAddressOut    <= beat_y;
        binaryDataOut  <= beat_bit;
        writeBinaryMem <= 1'b1;
        x_cnt          <= next_x;
        y_cnt          <= next_y;
      end

      case (state)
        IDLE: begin
          if (do_write) begin
            busy  <= 1'b1;
            state <= beat_last ? START : WRITE;
          end
        end
        WRITE: begin
          if (do_write) begin
            if (pixelSof) frameError <= 1'b1;
            if (beat_last) state <= START;
          end
        end
        START: begin
          // The last write strobe is out this cycle, so start lands one
          // cycle after it and never overlaps a write.
          start <= 1'b1;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (fullImageDone) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_frame_writer.sv
module tb_binary_frame_writer;

  logic       clk;
  logic       reset;
  logic [7:0] pixelIn;
  logic       pixelValid;
  logic       pixelSof;
  logic       pixelReady;
  logic [7:0] binThreshold;
  logic       fullImageDone;
  logic [7:0] xAddressOut;
  logic [7:0] yAddressOut;
  logic       binaryDataOut;
  logic       writeBinaryMem;
  logic       start;
  logic       busy;
  logic       frameError;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int start_cnt = 0;

  // Expected writes: {x[7:0], y[7:0], bit}
  logic [16:0] exp_q[$];

  binary_frame_writer #(
    .IMG_WIDTH (4),
    .IMG_HEIGHT(3),
    .ADDR_W    (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pixelIn       (pixelIn),
    .pixelValid    (pixelValid),
    .pixelSof      (pixelSof),
    .pixelReady    (pixelReady),
    .binThreshold  (binThreshold),
    .fullImageDone (fullImageDone),
    .xAddressOut   (xAddressOut),
    .yAddressOut   (yAddressOut),
    .binaryDataOut (binaryDataOut),
    .writeBinaryMem(writeBinaryMem),
    .start         (start),
    .busy          (busy),
    .frameError    (frameError)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one valid beat for one cycle; queue its write if one is expected.
  task automatic send(input logic [7:0] pix, input logic sof, input logic exp_wr,
                      input int x, input int y);
    pixelIn    = pix;
    pixelSof   = sof;
    pixelValid = 1'b1;
    if (exp_wr) exp_q.push_back({8'(x), 8'(y), (pix > binThreshold)});
    tick();
    pixelValid = 1'b0;
    pixelSof   = 1'b0;
  endtask

  // Last beat has been written; check the start pulse and release the frame.
  task automatic finish_frame(input string tag);
    check({tag, "_start_lo_at_wr"}, 32'(start), 32'd0);
    tick();
    check({tag, "_start_pulse"}, 32'(start), 32'd1);
    check({tag, "_ready_lo"}, 32'(pixelReady), 32'd0);
    fullImageDone = 1'b1;
    tick();
    check({tag, "_busy_released"}, 32'(busy), 32'd0);
    fullImageDone = 1'b0;
    check({tag, "_ready_idle"}, 32'(pixelReady), 32'd1);
  endtask

  // scoreboard: checks every write strobe against the expected queue
  always @(negedge clk) begin
    if (writeBinaryMem === 1'b1) begin
      logic [16:0] e;
      check("wr_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_x", 32'(xAddressOut), 32'(e[16:9]));
        check("wr_y", 32'(yAddressOut), 32'(e[8:1]));
        check("wr_data", 32'(binaryDataOut), 32'(e[0]));
      end
      check("wr_start_excl", 32'(start), 32'd0);
    end
    if (start === 1'b1) start_cnt++;
  end

  initial begin
    int ready_seen;
    reset = 1'b1; pixelIn = '0; pixelValid = 1'b0; pixelSof = 1'b0;
    binThreshold = 8'd100; fullImageDone = 1'b0;
    repeat (3) tick();
    check("rst_wr", 32'(writeBinaryMem), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ferr", 32'(frameError), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_ready", 32'(pixelReady), 32'd1);
    reset = 1'b0;
    tick();

    // Frame 1: 12 beats, pixel i*20 against threshold 100
    for (int i = 0; i < 12; i++) begin
      send(8'(i * 20), (i == 0), 1'b1, i % 4, i / 4);
      if (i == 0) check("f1_busy", 32'(busy), 32'd1);
    end
    check("f1_bit5_model", 32'(8'd100 > binThreshold), 32'd0);
    check("f1_start_lo_at_wr", 32'(start), 32'd0);
    tick();
    check("f1_start_pulse", 32'(start), 32'd1);
    // Hold valid beats while the filter is still working
    ready_seen = 0;
    pixelValid = 1'b1; pixelIn = 8'd200;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (pixelReady) ready_seen++;
    end
    pixelValid = 1'b0;
    check("wait_ready_lo", 32'(ready_seen), 32'd0);
    check("wait_busy", 32'(busy), 32'd1);
    check("f1_start_once", 32'(start_cnt), 32'd1);
    fullImageDone = 1'b1;
    tick();
    check("done_busy_lo", 32'(busy), 32'd0);
    fullImageDone = 1'b0;

    // Non-SOF beats in IDLE are dropped
    for (int i = 0; i < 3; i++) send(8'd255, 1'b0, 1'b0, 0, 0);
    check("idle_drop_busy", 32'(busy), 32'd0);
    check("idle_drop_wr", 32'(writeBinaryMem), 32'd0);

    // Threshold boundary: 100 -> 0, 101 -> 1
    send(8'd100, 1'b1, 1'b1, 0, 0);
    send(8'd101, 1'b0, 1'b1, 1, 0);
    check("thr_eq_bit", 32'(binaryDataOut), 32'd1);
    send(8'd50, 1'b0, 1'b1, 2, 0);
    send(8'd150, 1'b0, 1'b1, 3, 0);
    send(8'd99, 1'b0, 1'b1, 0, 1);
    check("ferr_before", 32'(frameError), 32'd0);
    // SOF after 5 pixels: restart at (0,0) and flag the error
    for (int i = 0; i < 12; i++)
      send(8'(i * 17 + 3), (i == 0), 1'b1, i % 4, i / 4);
    check("ferr_set", 32'(frameError), 32'd1);
    finish_frame("f2");
    check("f2_start_once", 32'(start_cnt), 32'd2);
    check("ferr_sticky", 32'(frameError), 32'd1);

    // Reset during pixel 7 with valid held
    binThreshold = 8'd128;
    for (int i = 0; i < 7; i++)
      send(8'(i * 40), (i == 0), 1'b1, i % 4, i / 4);
    pixelValid = 1'b1; pixelIn = 8'd250; reset = 1'b1;
    tick();
    check("mrst_wr", 32'(writeBinaryMem), 32'd0);
    check("mrst_x", 32'(xAddressOut), 32'd0);
    check("mrst_y", 32'(yAddressOut), 32'd0);
    check("mrst_data", 32'(binaryDataOut), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_ferr", 32'(frameError), 32'd0);
    check("mrst_start", 32'(start), 32'd0);
    check("mrst_ready", 32'(pixelReady), 32'd1);
    reset = 1'b0; pixelValid = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) send(8'd255, 1'b0, 1'b0, 0, 0);
    check("mrst_drop_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 12; i++)
      send(8'(i * 23), (i == 0), 1'b1, i % 4, i / 4);
    finish_frame("f3");
    check("f3_ferr_clear", 32'(frameError), 32'd0);

    repeat (2) tick();
    check("total_starts", 32'(start_cnt), 32'd3);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
